spi_reg_sequencer: RTL and testbench
====================================

# spi_reg_sequencer

Front-end sequencer that sits directly upstream of the generic SPI shifter (`spi_interface`) in the DAQ firmware. It accepts single register read/write commands from the slow-control logic and, on request, replays a boot-time configuration table from an external ROM. Each access is formatted as a 16-bit ADC-style instruction word (R/W bit, two zero width bits, 13-bit address) followed by 8 data bits. The block drives the shifter's request/busy handshake, enforces an inter-transaction gap, and flags shifter stalls.

## Interface
Parameters:
- `N_ENTRIES`, 16: maximum configuration ROM entries walked per init.
- `GAP_CYCLES`, 2: idle cycles enforced after each transaction (min 1).
- `START_TIMEOUT`, 3: cycles allowed for `spi_busy` to rise after `spi_request`.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_rw` in 1: 1 = read, 0 = write.
- `cmd_addr` in 13: register address.
- `cmd_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle pulse on completion of a host command.
- `rsp_rdata` out 8: read data; 0 for writes. Held until the next `rsp_valid`.
- `start_init` in 1: pulse to start ROM replay.
- `init_busy` out 1: ROM replay in progress.
- `init_done` out 1: replay finished. Cleared by `start_init`.
- `err` out 1: sticky timeout flag. Cleared by reset or by an accepted `start_init`.
- `rom_addr` out `$clog2(N_ENTRIES)`: ROM index.
- `rom_data` in 21: `{addr[12:0], data[7:0]}`. Valid one cycle after `rom_addr` changes.
- `spi_data_out` out 32: word to shift, MSB first.
- `spi_write_bits` out 6: bits to drive.
- `spi_read_bits` out 6: bits to capture.
- `spi_request` out 1: one-cycle request to the shifter.
- `spi_busy` in 1: shifter busy.
- `spi_data_in` in 32: shifter capture. Valid once `spi_busy` has fallen.

## Operation
- Write formatting: `spi_data_out = {1'b0, 2'b00, addr, data, 8'h00}`, `write_bits = 24`, `read_bits = 0`.
- Read formatting: `spi_data_out = {1'b1, 2'b00, addr, 16'h0000}`, `write_bits = 16`, `read_bits = 8`, `rsp_rdata = spi_data_in[7:0]`.
- The `spi_*` outputs are registered and held stable from the ISSUE cycle until the next ISSUE cycle.
- States:
  - IDLE: `cmd_ready = 1` only here and only if no init is pending. A pending `start_init` wins over a simultaneous `cmd_valid`.
    - Init pending → ROM_FETCH with `rom_addr = 0`.
    - Command accepted → ISSUE.
  - ROM_FETCH: wait one cycle for `rom_data`. If `rom_data[20:8] == 13'h1FFF` (terminator) → INIT_END; otherwise format a write → ISSUE.
  - ISSUE: `spi_request = 1` for exactly one cycle → WAIT_START.
  - WAIT_START: `spi_busy` high → WAIT_DONE. If `spi_busy` is still low after `START_TIMEOUT` cycles: set `err`, abort any active init (`init_busy = 0`, `init_done = 0`), host command returns `rsp_valid` with `rsp_rdata = 0` → GAP.
  - WAIT_DONE: first cycle `spi_busy` is sampled low → capture data; for a host command, pulse `rsp_valid` next cycle → GAP.
  - GAP: count `GAP_CYCLES`, then:
    - Init active and `rom_addr == N_ENTRIES-1` → INIT_END.
    - Init active otherwise → `rom_addr + 1`, ROM_FETCH.
    - No init active → IDLE.
  - INIT_END: `init_busy = 0`, `init_done = 1` → IDLE.
- `start_init` arriving outside IDLE is latched as pending and serviced at the next IDLE. A second pulse while one is already pending is absorbed. `start_init` during an active init is ignored.
- Reset, asynchronous with `reset_n` low:
  - State IDLE; init pending cleared.
  - Outputs `cmd_ready = 1` (after release), `rsp_valid = 0`, `rsp_rdata = 0`, `init_busy = 0`, `init_done = 0`, `err = 0`, `rom_addr = 0`, `spi_request = 0`, `spi_data_out = 0`, `spi_write_bits = 0`, `spi_read_bits = 0`.
  - An in-flight transaction is dropped with no response.

## Timing
- Command accepted at edge T → `spi_request` high during cycle T+1.
- With `spi_interface`, `spi_busy` rises at T+2. Busy lasts `write_bits + read_bits + 1` cycles, so it falls at T+27 for both read and write.
- `rsp_valid` pulses at T+28. `cmd_ready` returns at T+28+`GAP_CYCLES`.
- ROM entries issue every 29+`GAP_CYCLES` cycles, counting the ROM_FETCH cycle.
- `spi_request` is never asserted while `spi_busy` is high.
- `spi_request` is never asserted on two consecutive cycles.

## Test plan
- Host write `addr 0x0008`, `data 0x5A` → exactly one `spi_request` with `spi_data_out = 0x00085A00`, `write_bits = 24`, `read_bits = 0`; one `rsp_valid` with `rsp_rdata = 0x00`.
- Host read `addr 0x0001` with the SPI model returning `0x000000C3` → `spi_data_out = 0x80010000`, `write_bits = 16`, `read_bits = 8`, `rsp_rdata = 0xC3`.
- ROM holds 3 entries then terminator `0x1FFF` → 3 writes in order, `init_busy` high throughout, `init_done` set, `rom_addr` stops at 3, no `rsp_valid`.
- `start_init` and `cmd_valid` asserted in the same IDLE cycle → init runs first, `cmd_ready` low until `init_done`, then the command is accepted.
- SPI model never raises `busy` → `err` set after 3 cycles, `rsp_valid` with `rsp_rdata = 0`, `cmd_ready` back after the gap; the next `start_init` clears `err`.
- `reset_n` pulsed low mid-WAIT_DONE → all outputs at reset values immediately, no `rsp_valid`, and a new command is accepted after release.

Source files
------------

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: formats host register accesses and boot-time ROM replays
// into ADC-style instruction words for the downstream SPI shifter, paces them
// with an inter-transaction gap and flags shifter start timeouts.
module spi_reg_sequencer #(
    parameter int unsigned N_ENTRIES     = 16,
    parameter int unsigned GAP_CYCLES    = 2,
    parameter int unsigned START_TIMEOUT = 3,
    localparam int unsigned ROM_AW       = $clog2(N_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [12:0]       cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    input  logic              start_init,
    output logic              init_busy,
    output logic              init_done,
    output logic              err,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [20:0]       rom_data,
    output logic [31:0]       spi_data_out,
    output logic [5:0]        spi_write_bits,
    output logic [5:0]        spi_read_bits,
    output logic              spi_request,
    input  logic              spi_busy,
    input  logic [31:0]       spi_data_in
);

    localparam int unsigned CNT_MAX   = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [12:0] TERM_ADDR = 13'h1FFF;

    typedef enum logic [2:0] {
        IDLE,
        ROM_FETCH,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        GAP,
        INIT_END
    } state_t;

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                host_q, host_d;
    logic                is_read_q, is_read_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_rdata_q, rsp_rdata_d;
    logic                init_busy_q, init_busy_d;
    logic                init_done_q, init_done_d;
    logic                err_q, err_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [31:0]         spi_data_q, spi_data_d;
    logic [5:0]          spi_wbits_q, spi_wbits_d;
    logic [5:0]          spi_rbits_q, spi_rbits_d;
    logic                spi_req_q, spi_req_d;

    // Only the low byte of the shifter capture carries read data.
    logic unused_spi_hi;
    assign unused_spi_hi = ^spi_data_in[31:8];

    function automatic logic [31:0] fmt_write(input logic [12:0] addr, input logic [7:0] data);
        return {1'b0, 2'b00, addr, data, 8'h00};
    endfunction

    function automatic logic [31:0] fmt_read(input logic [12:0] addr);
        return {1'b1, 2'b00, addr, 16'h0000};
    endfunction

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        host_d      = host_q;
        is_read_d   = is_read_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        init_busy_d = init_busy_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        rom_addr_d  = rom_addr_q;
        spi_data_d  = spi_data_q;
        spi_wbits_d = spi_wbits_q;
        spi_rbits_d = spi_rbits_q;
        spi_req_d   = 1'b0;

        // A start request outside an active replay is remembered until IDLE.
        if (start_init && !init_busy_q) begin
            pend_d      = 1'b1;
            init_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pend_q || start_init) begin
                    pend_d      = 1'b0;
                    rom_addr_d  = '0;
                    init_busy_d = 1'b1;
                    init_done_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ROM_FETCH;
                end else if (cmd_valid && cmd_ready_q) begin
                    host_d    = 1'b1;
                    is_read_d = cmd_rw;
                    if (cmd_rw) begin
                        spi_data_d  = fmt_read(cmd_addr);
                        spi_wbits_d = 6'd16;
                        spi_rbits_d = 6'd8;
                    end else begin
                        spi_data_d  = fmt_write(cmd_addr, cmd_wdata);
                        spi_wbits_d = 6'd24;
                        spi_rbits_d = 6'd0;
                    end
                    state_d = ISSUE;
                end
            end

            ROM_FETCH: begin
                if (rom_data[20:8] == TERM_ADDR) begin
                    state_d = INIT_END;
                end else begin
                    host_d      = 1'b0;
                    is_read_d   = 1'b0;
                    spi_data_d  = fmt_write(rom_data[20:8], rom_data[7:0]);
                    spi_wbits_d = 6'd24;
                    spi_rbits_d = 6'd0;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                spi_req_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_START;
            end

            WAIT_START: begin
                if (spi_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    init_busy_d = 1'b0;
                    init_done_d = 1'b0;
                    if (host_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 8'h00;
                    end
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_DONE: begin
                if (!spi_busy) begin
                    if (host_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = is_read_q ? spi_data_in[7:0] : 8'h00;
                    end
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end

            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (!init_busy_q) begin
                        state_d = IDLE;
                    end else if (rom_addr_q == ROM_AW'(N_ENTRIES - 1)) begin
                        state_d = INIT_END;
                    end else begin
                        rom_addr_d = rom_addr_q + ROM_AW'(1);
                        state_d    = ROM_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            INIT_END: begin
                init_busy_d = 1'b0;
                init_done_d = 1'b1;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE) && !pend_d;
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            host_q      <= 1'b0;
            is_read_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            rom_addr_q  <= '0;
            spi_data_q  <= 32'h0;
            spi_wbits_q <= 6'd0;
            spi_rbits_q <= 6'd0;
            spi_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            host_q      <= host_d;
            is_read_q   <= is_read_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_busy_q <= init_busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            rom_addr_q  <= rom_addr_d;
            spi_data_q  <= spi_data_d;
            spi_wbits_q <= spi_wbits_d;
            spi_rbits_q <= spi_rbits_d;
            spi_req_q   <= spi_req_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign init_busy      = init_busy_q;
    assign init_done      = init_done_q;
    assign err            = err_q;
    assign rom_addr       = rom_addr_q;
    assign spi_data_out   = spi_data_q;
    assign spi_write_bits = spi_wbits_q;
    assign spi_read_bits  = spi_rbits_q;
    assign spi_request    = spi_req_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer with a cycle-accurate shifter model,
// a combinational config ROM and scoreboards for SPI words and host responses.
module tb_spi_reg_sequencer;

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  w;
        logic [5:0]  r;
    } spi_t;

    typedef struct packed {
        logic [7:0]  rd;
        logic [31:0] at;
    } rsp_t;

    logic        clk;
    logic        reset_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        start_init, init_busy, init_done, err;
    logic [3:0]  rom_addr;
    logic [20:0] rom_data;
    logic [31:0] spi_data_out;
    logic [5:0]  spi_write_bits, spi_read_bits;
    logic        spi_request;
    logic        spi_busy = 1'b0;
    logic [31:0] spi_data_in = 32'h0;

    logic [20:0] rom [0:15];
    logic [31:0] rd_value;
    logic        spi_dead;
    logic [6:0]  bcnt;
    logic        prev_req = 1'b0;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    spi_t        exp_spi [$];
    rsp_t        exp_rsp [$];
    int          req_q [$];
    spi_t        cur_spi;
    rsp_t        cur_rsp;

    spi_reg_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .start_init     (start_init),
        .init_busy      (init_busy),
        .init_done      (init_done),
        .err            (err),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .spi_data_out   (spi_data_out),
        .spi_write_bits (spi_write_bits),
        .spi_read_bits  (spi_read_bits),
        .spi_request    (spi_request),
        .spi_busy       (spi_busy),
        .spi_data_in    (spi_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = rom[rom_addr];

    // Shifter model: busy rises the edge after a request and lasts w+r+1 cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_busy <= 1'b0;
            bcnt     <= 7'd0;
        end else if (spi_busy) begin
            if (bcnt == 7'd1) begin
                spi_busy    <= 1'b0;
                spi_data_in <= rd_value;
            end
            bcnt <= bcnt - 7'd1;
        end else if (spi_request && !spi_dead) begin
            spi_busy <= 1'b1;
            bcnt     <= 7'(spi_write_bits) + 7'(spi_read_bits) + 7'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI word scoreboard and request protocol checks.
    always @(negedge clk) begin
        if (reset_n && spi_request) begin
            check("req_not_while_busy", 32'(spi_busy), 32'd0);
            check("req_not_back_to_back", 32'(prev_req), 32'd0);
            req_q.push_back(cyc);
            check("req_expected", 32'(exp_spi.size() > 0), 32'd1);
            if (exp_spi.size() > 0) begin
                cur_spi = exp_spi.pop_front();
                check("spi_data_out", spi_data_out, cur_spi.d);
                check("spi_write_bits", 32'(spi_write_bits), 32'(cur_spi.w));
                check("spi_read_bits", 32'(spi_read_bits), 32'(cur_spi.r));
            end
        end
        prev_req <= spi_request;
    end

    // Host response scoreboard, including response cycle.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            check("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
            if (exp_rsp.size() > 0) begin
                cur_rsp = exp_rsp.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(cur_rsp.rd));
                check("rsp_cycle", 32'(cyc), cur_rsp.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 10000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input int lat, input bit want_rsp,
                            output int acc, output logic done_at_acc);
        acc         = -1;
        done_at_acc = 1'b0;
        cmd_rw      = rw;
        cmd_addr    = addr;
        cmd_wdata   = wd;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready && !start_init) begin
                done_at_acc = init_done;
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
            start_init = 1'b0;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(acc >= 0), 32'd1);
        if (want_rsp && acc >= 0) exp_rsp.push_back('{exp_rd, 32'(acc + lat)});
    endtask

    task automatic wait_ready(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        check("ready_within_bound", 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_init(output logic dropped);
        logic done;
        done    = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (init_done) begin
                done = 1'b1;
                break;
            end
            if (!init_busy) dropped = 1'b1;
            @(negedge clk);
        end
        check("init_done_within_bound", 32'(done), 32'd1);
    endtask

    int   acc, rdy;
    logic dacc, dropped;

    initial begin
        cmd_valid  = 1'b0;
        cmd_rw     = 1'b0;
        cmd_addr   = 13'h0;
        cmd_wdata  = 8'h0;
        start_init = 1'b0;
        spi_dead   = 1'b0;
        rd_value   = 32'h0;
        for (int i = 0; i < 16; i++) rom[i] = {13'h1FFF, 8'h00};
        rom[0] = {13'h0010, 8'h01};
        rom[1] = {13'h0011, 8'h02};
        rom[2] = {13'h0A5F, 8'hC7};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_spi_request", 32'(spi_request), 32'd0);
        check("rst_spi_data_out", spi_data_out, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_release", 32'(cmd_ready), 32'd1);

        // Host write
        req_q.delete();
        rd_value = 32'hFFFF_FF3C;
        exp_spi.push_back('{32'h00085A00, 6'd24, 6'd0});
        send_cmd(1'b0, 13'h0008, 8'h5A, 8'h00, 28, 1'b1, acc, dacc);
        wait_ready(rdy);
        check("write_ready_return", 32'(rdy - acc), 32'd30);
        check("write_req_count", 32'(req_q.size()), 32'd1);
        if (req_q.size() > 0) check("write_req_latency", 32'(req_q[0] - acc), 32'd1);

        // Host read
        rd_value = 32'h000000C3;
        exp_spi.push_back('{32'h80010000, 6'd16, 6'd8});
        send_cmd(1'b1, 13'h0001, 8'h00, 8'hC3, 28, 1'b1, acc, dacc);
        wait_ready(rdy);
        check("read_ready_return", 32'(rdy - acc), 32'd30);

        // ROM replay of three entries
        req_q.delete();
        exp_spi.push_back('{32'h00100100, 6'd24, 6'd0});
        exp_spi.push_back('{32'h00110200, 6'd24, 6'd0});
        exp_spi.push_back('{32'h0A5FC700, 6'd24, 6'd0});
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        wait_init(dropped);
        check("init_busy_held", 32'(dropped), 32'd0);
        check("init_busy_after_done", 32'(init_busy), 32'd0);
        check("init_rom_addr_stop", 32'(rom_addr), 32'd3);
        check("init_req_count", 32'(req_q.size()), 32'd3);
        if (req_q.size() == 3) begin
            check("init_entry_period_0", 32'(req_q[1] - req_q[0]), 32'd31);
            check("init_entry_period_1", 32'(req_q[2] - req_q[1]), 32'd31);
        end
        wait_ready(rdy);

        // Shifter never starts
        spi_dead = 1'b1;
        rd_value = 32'h000000AB;
        exp_spi.push_back('{32'h00427700, 6'd24, 6'd0});
        send_cmd(1'b0, 13'h0042, 8'h77, 8'h00, 4, 1'b1, acc, dacc);
        wait_ready(rdy);
        check("timeout_ready_return", 32'(rdy - acc), 32'd6);
        check("timeout_err_set", 32'(err), 32'd1);
        spi_dead = 1'b0;
        repeat (3) @(negedge clk);
        check("timeout_err_sticky", 32'(err), 32'd1);
        rom[0] = {13'h1FFF, 8'h00};
        start_init = 1'b1;
        @(negedge clk);
        start_init = 1'b0;
        check("err_cleared_by_init", 32'(err), 32'd0);
        wait_init(dropped);
        check("empty_init_rom_addr", 32'(rom_addr), 32'd0);
        wait_ready(rdy);

        // start_init and cmd_valid in the same IDLE cycle
        rom[0] = {13'h0010, 8'h01};
        rd_value = 32'hA5A5A55C;
        exp_spi.push_back('{32'h00100100, 6'd24, 6'd0});
        exp_spi.push_back('{32'h00110200, 6'd24, 6'd0});
        exp_spi.push_back('{32'h0A5FC700, 6'd24, 6'd0});
        exp_spi.push_back('{32'h81230000, 6'd16, 6'd8});
        start_init = 1'b1;
        send_cmd(1'b1, 13'h0123, 8'h00, 8'h5C, 28, 1'b1, acc, dacc);
        check("collision_init_first", 32'(dacc), 32'd1);
        wait_ready(rdy);
        check("collision_err_clear", 32'(err), 32'd0);

        // Reset in the middle of WAIT_DONE
        exp_spi.push_back('{32'h80020000, 6'd16, 6'd8});
        send_cmd(1'b1, 13'h0002, 8'h00, 8'h00, 28, 1'b0, acc, dacc);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(spi_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        check("mid_rst_init_busy", 32'(init_busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_spi_request", 32'(spi_request), 32'd0);
        check("mid_rst_spi_data_out", spi_data_out, 32'h0);
        check("mid_rst_write_bits", 32'(spi_write_bits), 32'd0);
        check("mid_rst_read_bits", 32'(spi_read_bits), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
        exp_spi.push_back('{32'h00101100, 6'd24, 6'd0});
        send_cmd(1'b0, 13'h0010, 8'h11, 8'h00, 28, 1'b1, acc, dacc);
        wait_ready(rdy);
        check("post_reset_ready_return", 32'(rdy - acc), 32'd30);

        repeat (5) @(negedge clk);
        check("spi_scoreboard_drained", 32'(exp_spi.size()), 32'd0);
        check("rsp_scoreboard_drained", 32'(exp_rsp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
